// File: rtl/clownfish_fp_pkg.sv
// Shared FP definitions: opcode and rounding-mode encodings, tag/ROB widths,
// and the per-opcode operand-need mask.
package clownfish_fp_pkg;

  localparam int TAG_W    = 7;
  localparam int ROB_ID_W = 6;
  localparam int OP_W     = 5;
  localparam int RM_W     = 3;

  localparam logic [OP_W-1:0] OP_FADD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_FSUB   = 5'b00001;
  localparam logic [OP_W-1:0] OP_FMUL   = 5'b00010;
  localparam logic [OP_W-1:0] OP_FDIV   = 5'b00011;
  localparam logic [OP_W-1:0] OP_FSQRT  = 5'b00100;
  localparam logic [OP_W-1:0] OP_FMADD  = 5'b00101;
  localparam logic [OP_W-1:0] OP_FMSUB  = 5'b00110;
  localparam logic [OP_W-1:0] OP_FNMSUB = 5'b00111;
  localparam logic [OP_W-1:0] OP_FNMADD = 5'b01000;
  localparam logic [OP_W-1:0] OP_FSGNJ  = 5'b01001;
  localparam logic [OP_W-1:0] OP_FSGNJN = 5'b01010;
  localparam logic [OP_W-1:0] OP_FSGNJX = 5'b01011;
  localparam logic [OP_W-1:0] OP_FMIN   = 5'b01100;
  localparam logic [OP_W-1:0] OP_FMAX   = 5'b01101;
  localparam logic [OP_W-1:0] OP_FCVT   = 5'b01110;
  localparam logic [OP_W-1:0] OP_FMV    = 5'b01111;
  localparam logic [OP_W-1:0] OP_FCMP   = 5'b10000;
  localparam logic [OP_W-1:0] OP_FCLASS = 5'b10001;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  // Returns {c, b, a}: which source operands the opcode actually reads.
  function automatic logic [2:0] operand_need(input logic [OP_W-1:0] op);
    logic [2:0] need;
    need = 3'b011;
    if (op == OP_FSQRT || op == OP_FCVT || op == OP_FMV || op == OP_FCLASS)
      need = 3'b001;
    else if (op >= OP_FMADD && op <= OP_FNMADD)
      need = 3'b111;
    return need;
  endfunction

endpackage

// File: rtl/fp_issue_queue_if.sv
// FPU request channel: the issue queue is the master (valid), the FPU the slave (ready).
interface fp_issue_queue_if #(
  parameter int TAG_W  = 7,
  parameter int DATA_W = 64
);
  import clownfish_fp_pkg::*;

  logic                fpu_valid_o;
  logic                fpu_ready_i;
  logic [OP_W-1:0]     fpu_op_o;
  logic                fpu_is_double_o;
  logic [RM_W-1:0]     fpu_rm_o;
  logic [ROB_ID_W-1:0] fpu_rob_id_o;
  logic [TAG_W-1:0]    fpu_phys_dest_o;
  logic [DATA_W-1:0]   fpu_operand_a_o;
  logic [DATA_W-1:0]   fpu_operand_b_o;
  logic [DATA_W-1:0]   fpu_operand_c_o;

  modport master (
    output fpu_valid_o, fpu_op_o, fpu_is_double_o, fpu_rm_o, fpu_rob_id_o,
           fpu_phys_dest_o, fpu_operand_a_o, fpu_operand_b_o, fpu_operand_c_o,
    input  fpu_ready_i
  );

  modport slave (
    input  fpu_valid_o, fpu_op_o, fpu_is_double_o, fpu_rm_o, fpu_rob_id_o,
           fpu_phys_dest_o, fpu_operand_a_o, fpu_operand_b_o, fpu_operand_c_o,
    output fpu_ready_i
  );

endinterface

// File: rtl/fp_iq_entry.sv
// One issue-queue slot: loads from dispatch or shifts down from the slot above,
// and captures writeback data into any waiting source on a tag match.
module fp_iq_entry #(
  parameter int TAG_W  = 7,
  parameter int DATA_W = 64,
  parameter int META_W = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   shift,
  input  logic [META_W-1:0]      enq_meta,
  input  logic [2:0][TAG_W-1:0]  enq_tag,
  input  logic [2:0]             enq_rdy,
  input  logic [2:0][DATA_W-1:0] enq_data,
  input  logic                   above_valid,
  input  logic [META_W-1:0]      above_meta,
  input  logic [2:0][TAG_W-1:0]  above_tag,
  input  logic [2:0]             above_rdy,
  input  logic [2:0][DATA_W-1:0] above_data,
  input  logic                   wb_valid,
  input  logic [TAG_W-1:0]       wb_tag,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   valid_q,
  output logic [META_W-1:0]      meta_q,
  output logic [2:0][TAG_W-1:0]  tag_q,
  output logic [2:0]             rdy_q,
  output logic [2:0][DATA_W-1:0] data_q
);

  logic                   cur_valid;
  logic [META_W-1:0]      cur_meta;
  logic [2:0][TAG_W-1:0]  cur_tag;
  logic [2:0]             cur_rdy;
  logic [2:0][DATA_W-1:0] cur_data;
  logic [2:0]             hit;
  logic [2:0]             nxt_rdy;
  logic [2:0][DATA_W-1:0] nxt_data;

  // Wakeup is applied to whichever source feeds the slot, so a shifting entry
  // and an enqueuing one (bypass) both catch a same-cycle broadcast.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_valid = valid_q;
    cur_meta  = meta_q;
    cur_tag   = tag_q;
    cur_rdy   = rdy_q;
    cur_data  = data_q;
    if (load) begin
      cur_valid = 1'b1;
      cur_meta  = enq_meta;
      cur_tag   = enq_tag;
      cur_rdy   = enq_rdy;
      cur_data  = enq_data;
    end else if (shift) begin
      cur_valid = above_valid;
      cur_meta  = above_meta;
      cur_tag   = above_tag;
      cur_rdy   = above_rdy;
      cur_data  = above_data;
    end
    for (int s = 0; s < 3; s++) begin
      hit[s]      = wb_valid && !cur_rdy[s] && (cur_tag[s] == wb_tag);
      nxt_rdy[s]  = cur_rdy[s] | hit[s];
      nxt_data[s] = hit[s] ? wb_data : cur_data[s];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all slots update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= cur_valid;
      rdy_q   <= nxt_rdy;
    end
  end

  // NOTE: payload is storage qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    meta_q <= cur_meta;
    tag_q  <= cur_tag;
    data_q <= nxt_data;
  end

endmodule

// File: rtl/fp_issue_queue.sv
// Age-ordered collapsing FP issue queue: captures operands, wakes on writeback,
// and offers the oldest fully-ready entry to the FPU.
module fp_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = clownfish_fp_pkg::TAG_W,
  parameter int DATA_W = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic                                  enq_valid_i,
  output logic                                  enq_ready_o,
  input  logic [clownfish_fp_pkg::OP_W-1:0]     enq_op_i,
  input  logic                                  enq_is_double_i,
  input  logic [clownfish_fp_pkg::RM_W-1:0]     enq_rm_i,
  input  logic [clownfish_fp_pkg::ROB_ID_W-1:0] enq_rob_id_i,
  input  logic [TAG_W-1:0]                      enq_phys_dest_i,
  input  logic [TAG_W-1:0]                      enq_srca_tag_i,
  input  logic [TAG_W-1:0]                      enq_srcb_tag_i,
  input  logic [TAG_W-1:0]                      enq_srcc_tag_i,
  input  logic                                  enq_srca_rdy_i,
  input  logic                                  enq_srcb_rdy_i,
  input  logic                                  enq_srcc_rdy_i,
  input  logic [DATA_W-1:0]                     enq_srca_data_i,
  input  logic [DATA_W-1:0]                     enq_srcb_data_i,
  input  logic [DATA_W-1:0]                     enq_srcc_data_i,
  input  logic                                  wb_valid_i,
  input  logic [TAG_W-1:0]                      wb_tag_i,
  input  logic [DATA_W-1:0]                     wb_data_i,
  fp_issue_queue_if.master                      fpu,
  output logic [$clog2(DEPTH):0]                count_o
);
  import clownfish_fp_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int META_W = OP_W + 1 + RM_W + ROB_ID_W + TAG_W;

  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       enq_idx;
  logic [CNT_W-1:0]       sel_idx;
  logic                   enq_fire;
  logic                   issue_fire;
  logic [2:0]             need;
  logic [META_W-1:0]      enq_meta;
  logic [2:0][TAG_W-1:0]  enq_tag;
  logic [2:0]             enq_rdy;
  logic [2:0][DATA_W-1:0] enq_data;
  logic [DEPTH-1:0]       eligible;
  logic [META_W-1:0]      sel_meta;
  logic [2:0][DATA_W-1:0] sel_data;

  // Index DEPTH is a permanently empty slot feeding the top entry's shift port.
  logic [DEPTH:0]         e_valid;
  logic [META_W-1:0]      e_meta [DEPTH+1];
  logic [2:0][TAG_W-1:0]  e_tag  [DEPTH+1];
  logic [2:0]             e_rdy  [DEPTH+1];
  logic [2:0][DATA_W-1:0] e_data [DEPTH+1];

  assign e_valid[DEPTH] = 1'b0;
  assign e_meta[DEPTH]  = '0;
  assign e_tag[DEPTH]   = '0;
  assign e_rdy[DEPTH]   = '0;
  assign e_data[DEPTH]  = '0;

  // Unused operands enter ready with zero data so they never gate issue.
  assign need     = operand_need(enq_op_i);
  assign enq_meta = {enq_op_i, enq_is_double_i, enq_rm_i, enq_rob_id_i, enq_phys_dest_i};
  assign enq_tag  = {enq_srcc_tag_i, enq_srcb_tag_i, enq_srca_tag_i};
  assign enq_rdy  = {enq_srcc_rdy_i, enq_srcb_rdy_i, enq_srca_rdy_i} | ~need;
  assign enq_data = {need[2] ? enq_srcc_data_i : '0,
                     need[1] ? enq_srcb_data_i : '0,
                     need[0] ? enq_srca_data_i : '0};

  assign enq_ready_o = (count_q != CNT_W'(DEPTH));
  assign enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
  assign issue_fire  = fpu.fpu_valid_o && fpu.fpu_ready_i;
  assign enq_idx     = count_q - CNT_W'(issue_fire);
  assign count_o     = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign eligible[i] = e_valid[i] && (&e_rdy[i]);

    fp_iq_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W), .META_W(META_W)) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush_i),
      .load        (enq_fire && (enq_idx == CNT_W'(i))),
      .shift       (issue_fire && (CNT_W'(i) >= sel_idx)),
      .enq_meta    (enq_meta),
      .enq_tag     (enq_tag),
      .enq_rdy     (enq_rdy),
      .enq_data    (enq_data),
      .above_valid (e_valid[i+1]),
      .above_meta  (e_meta[i+1]),
      .above_tag   (e_tag[i+1]),
      .above_rdy   (e_rdy[i+1]),
      .above_data  (e_data[i+1]),
      .wb_valid    (wb_valid_i),
      .wb_tag      (wb_tag_i),
      .wb_data     (wb_data_i),
      .valid_q     (e_valid[i]),
      .meta_q      (e_meta[i]),
      .tag_q       (e_tag[i]),
      .rdy_q       (e_rdy[i]),
      .data_q      (e_data[i])
    );
  end

  // Scanning from the top lets the lowest (oldest) eligible index win.
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = CNT_W'(i);
    end
  end

  assign sel_meta = e_meta[sel_idx];
  assign sel_data = e_data[sel_idx];

  assign fpu.fpu_valid_o     = (|eligible) && !flush_i;
  assign fpu.fpu_op_o        = fpu.fpu_valid_o ? sel_meta[META_W-1 -: OP_W] : '0;
  assign fpu.fpu_is_double_o = fpu.fpu_valid_o && sel_meta[META_W-OP_W-1];
  assign fpu.fpu_rm_o        = fpu.fpu_valid_o ? sel_meta[ROB_ID_W+TAG_W +: RM_W] : '0;
  assign fpu.fpu_rob_id_o    = fpu.fpu_valid_o ? sel_meta[TAG_W +: ROB_ID_W] : '0;
  assign fpu.fpu_phys_dest_o = fpu.fpu_valid_o ? sel_meta[TAG_W-1:0] : '0;
  assign fpu.fpu_operand_a_o = fpu.fpu_valid_o ? sel_data[0] : '0;
  assign fpu.fpu_operand_b_o = fpu.fpu_valid_o ? sel_data[1] : '0;
  assign fpu.fpu_operand_c_o = fpu.fpu_valid_o ? sel_data[2] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_q <= '0;
    else if (flush_i) count_q <= '0;
    else              count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);
  end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue: reset, operand capture, wakeup/bypass,
// out-of-order issue, full-queue behaviour and flush.
module tb_fp_issue_queue;
  import clownfish_fp_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [4:0]        enq_op_i;
  logic              enq_is_double_i;
  logic [2:0]        enq_rm_i;
  logic [5:0]        enq_rob_id_i;
  logic [6:0]        enq_phys_dest_i;
  logic [6:0]        enq_srca_tag_i, enq_srcb_tag_i, enq_srcc_tag_i;
  logic              enq_srca_rdy_i, enq_srcb_rdy_i, enq_srcc_rdy_i;
  logic [DATA_W-1:0] enq_srca_data_i, enq_srcb_data_i, enq_srcc_data_i;
  logic              wb_valid_i;
  logic [6:0]        wb_tag_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              fpu_ready;
  logic [3:0]        count_o;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  fp_issue_queue_if #(.TAG_W(7), .DATA_W(DATA_W)) fpu ();
  assign fpu.fpu_ready_i = fpu_ready;

  fp_issue_queue #(.DEPTH(DEPTH), .TAG_W(7), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .enq_valid_i     (enq_valid_i),
    .enq_ready_o     (enq_ready_o),
    .enq_op_i        (enq_op_i),
    .enq_is_double_i (enq_is_double_i),
    .enq_rm_i        (enq_rm_i),
    .enq_rob_id_i    (enq_rob_id_i),
    .enq_phys_dest_i (enq_phys_dest_i),
    .enq_srca_tag_i  (enq_srca_tag_i),
    .enq_srcb_tag_i  (enq_srcb_tag_i),
    .enq_srcc_tag_i  (enq_srcc_tag_i),
    .enq_srca_rdy_i  (enq_srca_rdy_i),
    .enq_srcb_rdy_i  (enq_srcb_rdy_i),
    .enq_srcc_rdy_i  (enq_srcc_rdy_i),
    .enq_srca_data_i (enq_srca_data_i),
    .enq_srcb_data_i (enq_srcb_data_i),
    .enq_srcc_data_i (enq_srcc_data_i),
    .wb_valid_i      (wb_valid_i),
    .wb_tag_i        (wb_tag_i),
    .wb_data_i       (wb_data_i),
    .fpu             (fpu.master),
    .count_o         (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic enq(input logic [4:0] op, input logic [5:0] rob,
                     input logic [6:0] ta, input logic ra, input logic [63:0] da,
                     input logic [6:0] tb, input logic rb, input logic [63:0] db,
                     input logic [6:0] tc, input logic rc, input logic [63:0] dc);
    enq_valid_i     = 1'b1;
    enq_op_i        = op;
    enq_is_double_i = 1'b1;
    enq_rm_i        = RM_RNE;
    enq_rob_id_i    = rob;
    enq_phys_dest_i = {1'b0, rob};
    enq_srca_tag_i  = ta; enq_srca_rdy_i = ra; enq_srca_data_i = da;
    enq_srcb_tag_i  = tb; enq_srcb_rdy_i = rb; enq_srcb_data_i = db;
    enq_srcc_tag_i  = tc; enq_srcc_rdy_i = rc; enq_srcc_data_i = dc;
  endtask

  task automatic wb(input logic [6:0] tag, input logic [63:0] data);
    wb_valid_i = 1'b1;
    wb_tag_i   = tag;
    wb_data_i  = data;
  endtask

  logic [5:0] exp_order [7];

  initial begin
    exp_order = '{6'd20, 6'd21, 6'd22, 6'd24, 6'd25, 6'd26, 6'd27};
    rst_n = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0; fpu_ready = 1'b0;
    enq_op_i = '0; enq_is_double_i = 1'b0; enq_rm_i = '0; enq_rob_id_i = '0;
    enq_phys_dest_i = '0;
    enq_srca_tag_i = '0; enq_srcb_tag_i = '0; enq_srcc_tag_i = '0;
    enq_srca_rdy_i = 1'b0; enq_srcb_rdy_i = 1'b0; enq_srcc_rdy_i = 1'b0;
    enq_srca_data_i = '0; enq_srcb_data_i = '0; enq_srcc_data_i = '0;
    wb_valid_i = 1'b0; wb_tag_i = '0; wb_data_i = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    settle();

    // Reset state
    check("rst_enq_ready", enq_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_fpu_valid", fpu.fpu_valid_o, 0);
    check("rst_operand_a", fpu.fpu_operand_a_o, 0);

    // FADD with both operands ready; c unused so forced to 0
    fpu_ready = 1'b1;
    enq(OP_FADD, 6'd1, 7'h01, 1'b1, 64'h3F800000, 7'h02, 1'b1, 64'h40000000,
        7'h03, 1'b0, 64'hDEAD);
    settle();
    check("fadd_enq_cycle_valid", fpu.fpu_valid_o, 0);
    step();
    enq_valid_i = 1'b0;
    settle();
    check("fadd_count1", count_o, 1);
    check("fadd_valid", fpu.fpu_valid_o, 1);
    check("fadd_op", fpu.fpu_op_o, OP_FADD);
    check("fadd_a", fpu.fpu_operand_a_o, 64'h3F800000);
    check("fadd_b", fpu.fpu_operand_b_o, 64'h40000000);
    check("fadd_c_zero", fpu.fpu_operand_c_o, 0);
    check("fadd_rob", fpu.fpu_rob_id_o, 1);
    check("fadd_dest", fpu.fpu_phys_dest_o, 1);
    step();
    settle();
    check("fadd_count0", count_o, 0);
    check("fadd_gone", fpu.fpu_valid_o, 0);

    // FMUL waiting on tag 0x25, woken two cycles later
    enq(OP_FMUL, 6'd2, 7'h04, 1'b1, 64'h3FC00000, 7'h25, 1'b0, 64'h0,
        7'h05, 1'b0, 64'h1234);
    step();
    enq_valid_i = 1'b0;
    settle();
    check("wake_blocked", fpu.fpu_valid_o, 0);
    check("wake_count1", count_o, 1);
    step();
    wb(7'h25, 64'h40400000);
    settle();
    check("wake_cycle_not_eligible", fpu.fpu_valid_o, 0);
    step();
    wb_valid_i = 1'b0;
    settle();
    check("wake_valid", fpu.fpu_valid_o, 1);
    check("wake_b", fpu.fpu_operand_b_o, 64'h40400000);
    check("wake_a", fpu.fpu_operand_a_o, 64'h3FC00000);
    check("wake_rob", fpu.fpu_rob_id_o, 2);
    step();
    settle();
    check("wake_count0", count_o, 0);

    // Same-cycle writeback bypass at enqueue
    enq(OP_FMUL, 6'd3, 7'h04, 1'b1, 64'h3FC00000, 7'h25, 1'b0, 64'h0,
        7'h05, 1'b0, 64'h0);
    wb(7'h25, 64'h40A00000);
    settle();
    check("bypass_enq_cycle_valid", fpu.fpu_valid_o, 0);
    step();
    enq_valid_i = 1'b0;
    wb_valid_i  = 1'b0;
    settle();
    check("bypass_valid", fpu.fpu_valid_o, 1);
    check("bypass_b", fpu.fpu_operand_b_o, 64'h40A00000);
    check("bypass_rob", fpu.fpu_rob_id_o, 3);
    step();
    settle();
    check("bypass_count0", count_o, 0);

    // Out-of-order issue: X blocked, Y and Z pass it
    enq(OP_FADD, 6'd10, 7'h30, 1'b0, 64'h0, 7'h06, 1'b1, 64'h1, 7'h00, 1'b0, 64'h0);
    step();
    enq(OP_FADD, 6'd11, 7'h07, 1'b1, 64'h11, 7'h08, 1'b1, 64'h12, 7'h00, 1'b0, 64'h0);
    settle();
    check("ooo_x_blocked", fpu.fpu_valid_o, 0);
    step();
    enq(OP_FADD, 6'd12, 7'h09, 1'b1, 64'h21, 7'h0A, 1'b1, 64'h22, 7'h00, 1'b0, 64'h0);
    settle();
    check("ooo_y_valid", fpu.fpu_valid_o, 1);
    check("ooo_y_rob", fpu.fpu_rob_id_o, 11);
    step();
    enq_valid_i = 1'b0;
    settle();
    check("ooo_z_rob", fpu.fpu_rob_id_o, 12);
    check("ooo_z_b", fpu.fpu_operand_b_o, 64'h22);
    step();
    wb(7'h30, 64'h41000000);
    settle();
    check("ooo_x_still_blocked", fpu.fpu_valid_o, 0);
    check("ooo_count1", count_o, 1);
    step();
    wb_valid_i = 1'b0;
    settle();
    check("ooo_x_valid", fpu.fpu_valid_o, 1);
    check("ooo_x_rob", fpu.fpu_rob_id_o, 10);
    check("ooo_x_a", fpu.fpu_operand_a_o, 64'h41000000);
    step();
    settle();
    check("ooo_count0", count_o, 0);

    // Fill with eight blocked single-operand entries
    fpu_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      enq(OP_FSQRT, 6'(20 + i), 7'(8'h40 + i), 1'b0, 64'h0,
          7'h00, 1'b0, 64'h0, 7'h00, 1'b0, 64'h0);
      step();
    end
    enq_valid_i = 1'b0;
    settle();
    check("full_count", count_o, 8);
    check("full_enq_ready", enq_ready_o, 0);
    check("full_no_issue", fpu.fpu_valid_o, 0);
    enq(OP_FSQRT, 6'd63, 7'h4F, 1'b1, 64'h99, 7'h00, 1'b0, 64'h0, 7'h00, 1'b0, 64'h0);
    step();
    enq_valid_i = 1'b0;
    settle();
    check("full_drop_count", count_o, 8);
    check("full_drop_no_valid", fpu.fpu_valid_o, 0);
    wb(7'h43, 64'h55);
    step();
    wb_valid_i = 1'b0;
    settle();
    check("mid_valid", fpu.fpu_valid_o, 1);
    check("mid_rob", fpu.fpu_rob_id_o, 23);
    check("mid_a", fpu.fpu_operand_a_o, 64'h55);
    step();
    settle();
    check("mid_hold_valid", fpu.fpu_valid_o, 1);
    check("mid_hold_rob", fpu.fpu_rob_id_o, 23);
    check("mid_hold_count", count_o, 8);
    fpu_ready = 1'b1;
    step();
    fpu_ready = 1'b0;
    settle();
    check("mid_count7", count_o, 7);
    check("mid_enq_ready", enq_ready_o, 1);
    check("mid_gone", fpu.fpu_valid_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 3) begin
        wb(7'(8'h40 + i), 64'(i));
        step();
      end
    end
    wb_valid_i = 1'b0;
    fpu_ready  = 1'b1;
    settle();
    for (int k = 0; k < 7; k++) begin
      check($sformatf("order_rob_%0d", k), fpu.fpu_rob_id_o, exp_order[k]);
      step();
      settle();
    end
    check("order_count0", count_o, 0);

    // Flush with simultaneous enqueue, eligible entry and wakeup
    fpu_ready = 1'b0;
    enq(OP_FADD, 6'd40, 7'h01, 1'b1, 64'hA, 7'h02, 1'b1, 64'hB, 7'h00, 1'b0, 64'h0);
    step();
    for (int i = 1; i < 5; i++) begin
      enq(OP_FSQRT, 6'(40 + i), 7'(8'h50 + i), 1'b0, 64'h0,
          7'h00, 1'b0, 64'h0, 7'h00, 1'b0, 64'h0);
      step();
    end
    enq_valid_i = 1'b0;
    settle();
    check("pre_flush_count", count_o, 5);
    check("pre_flush_valid", fpu.fpu_valid_o, 1);
    check("pre_flush_rob", fpu.fpu_rob_id_o, 40);
    flush_i = 1'b1;
    fpu_ready = 1'b1;
    enq(OP_FADD, 6'd45, 7'h01, 1'b1, 64'h1, 7'h02, 1'b1, 64'h2, 7'h00, 1'b0, 64'h0);
    wb(7'h51, 64'h77);
    settle();
    check("flush_cycle_valid", fpu.fpu_valid_o, 0);
    check("flush_cycle_rob", fpu.fpu_rob_id_o, 0);
    step();
    flush_i     = 1'b0;
    enq_valid_i = 1'b0;
    wb_valid_i  = 1'b0;
    settle();
    check("post_flush_count", count_o, 0);
    check("post_flush_valid", fpu.fpu_valid_o, 0);
    check("post_flush_enq_ready", enq_ready_o, 1);
    step();
    step();
    settle();
    check("post_flush_quiet_valid", fpu.fpu_valid_o, 0);
    check("post_flush_quiet_count", count_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_issue_queue.md
Name: fp_issue_queue

Overview:
- Age-ordered, data-capturing issue queue that feeds the floating-point execution unit.
- Accepts renamed FP micro-ops from dispatch and captures operand values at enqueue or from the FP writeback broadcast.
- Drives the FPU request interface (valid/ready) with the oldest operand-ready entry.
- Sits between rename/dispatch and the FPU; acts as the initiator side of the FPU's valid_i/ready_o protocol.

Parameters:
DEPTH, 8, number of queue entries (power of two, >=2)
TAG_W, 7, physical register tag width
DATA_W, 64, operand width (double precision)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous kill of all entries (mispredict/exception)
enq_valid_i  in  1  dispatch offers a micro-op
enq_ready_o  out  1  queue can accept (count != DEPTH)
enq_op_i  in  5  FPU opcode
enq_is_double_i  in  1  double precision
enq_rm_i  in  3  rounding mode
enq_rob_id_i  in  6  ROB index
enq_phys_dest_i  in  TAG_W  destination tag
enq_src{a,b,c}_tag_i  in  TAG_W  source tags
enq_src{a,b,c}_rdy_i  in  1  source value already valid
enq_src{a,b,c}_data_i  in  DATA_W  source value, meaningful when rdy
wb_valid_i  in  1  FP writeback broadcast valid
wb_tag_i  in  TAG_W  writeback destination tag
wb_data_i  in  DATA_W  writeback value
fpu_valid_o  out  1  request to FPU
fpu_ready_i  in  1  FPU ready
fpu_op_o, fpu_is_double_o, fpu_rm_o, fpu_rob_id_o, fpu_phys_dest_o  out  5/1/3/6/TAG_W  selected entry fields
fpu_operand_{a,b,c}_o  out  DATA_W  selected entry operands
count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async): all entries invalid, count_o=0. enq_ready_o=1 and fpu_valid_o=0 once reset deasserts. All fpu_* data outputs are 0 whenever fpu_valid_o=0.
- Storage is a collapsing shift queue. Index 0 holds the oldest entry; valid entries are contiguous from index 0.
- Operand need mask:
  - opcodes 00100 (FSQRT), 01110 (FCVT), 01111 (FMV), 10001 (FCLASS) use a only;
  - 00101–01000 (fused multiply-add family) use a, b and c;
  - all other opcodes use a and b.
  - Unused operands are forced ready at enqueue and their data is captured as 0.
- Enqueue fires on enq_valid_i && enq_ready_o && !flush_i. The new entry is written at index count, or count-1 if an issue fires in the same cycle.
- Enqueue bypass: if a source is not ready and wb_valid_i && wb_tag_i matches its tag in the same cycle, the source is captured ready with wb_data_i.
- Wakeup: every valid entry source with rdy=0 and a matching wb_tag_i sets rdy=1 and captures wb_data_i. Multiple matches are all updated.
- Readiness timing: an entry is eligible only when all three rdy bits are 1 in registered state. An entry woken in cycle t is eligible in t+1. An entry enqueued in t is eligible in t+1 at the earliest.
- Select: lowest eligible index. fpu_valid_o and fpu_* are combinational from registered entry state, gated by !flush_i.
- Issue fires on fpu_valid_o && fpu_ready_i. In the next cycle the selected entry is removed and all entries above it shift down one.
- fpu_valid_o may be asserted with fpu_ready_i=0. In that case the entry holds, and the selection may change next cycle if an older entry becomes eligible.
- Full: count=DEPTH gives enq_ready_o=0. Enqueue is not accepted even if an issue fires in the same cycle; there is no pass-through.
- flush_i: next cycle count=0 and all entries are invalid. Same-cycle enqueue, issue and wakeup are discarded. flush_i has priority over everything.
- count_o = previous count + enqueue fired − issue fired. It never exceeds DEPTH.

Decomposition:
- Shared package clownfish_fp_pkg holds:
  - FPU opcode localparams (00000–10001) and rounding-mode codes;
  - the operand-need-mask function;
  - TAG_W and ROB_ID_W.
- Sub-module fp_iq_entry holds one slot: fields, three rdy/data pairs, tag comparators, wakeup capture, and a shift-in port from the entry above.
- The top level contains the count, the enqueue/shift control and the oldest-ready priority select.

Test Plan:
1. Reset, no stimulus -> enq_ready_o=1, count_o=0, fpu_valid_o=0, fpu_operand_a_o=0.
2. Enqueue FADD (op 00000), a=0x3F800000 ready, b=0x40000000 ready, fpu_ready_i=1 -> fpu_valid_o=1 the next cycle with the matching operands and operand_c=0; count_o goes 1 then 0.
3. Enqueue FMUL with b tag 0x25 not ready; two cycles later wb tag 0x25, data 0x40400000 -> fpu_valid_o one cycle after wakeup, operand_b=0x40400000. Repeat with the wb match in the enqueue cycle -> issue the next cycle (bypass).
4. Enqueue X (blocked on tag 0x30), then Y and Z (ready) with fpu_ready_i=1 -> issue order Y, Z. Then wb tag 0x30 -> X issues; rob_ids observed in order Y, Z, X.
5. Fill 8 blocked entries -> enq_ready_o=0, count_o=8, a 9th enq_valid_i is dropped. Wake the entry at index 3 with fpu_ready_i=1 -> it issues, count_o=7, enq_ready_o=1, remaining order preserved.
6. Hold 5 entries, assert flush_i with a simultaneous enqueue and an eligible entry and fpu_ready_i=1 -> no fpu_valid_o in the flush cycle, count_o=0 next cycle, no later issue.
